// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
// State encodings are fixed so that debug tooling can decode the state register.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Subtraction is a + ~b + 1, so the carry chain always starts at 1 in that mode.
    function automatic logic carry_init(input logic sub_mode, input logic cin_bit);
        return sub_mode ? 1'b1 : cin_bit;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the serial sequencer.
module full_adder (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic c
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: time-shares one full_adder cell, LSB first,
// one bit per clock, with a start/done handshake towards the master.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic               load_s;
    logic               last_s;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               fa_sum_s;
    logic               fa_carry_s;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;

    full_adder u_fa (
        .sum   (fa_sum_s),
        .carry (fa_carry_s),
        .a     (a_sr_r[0]),
        .b     (b_sr_r[0]),
        .c     (carry_r)
    );

    // Next-state decode and operand-load strobe.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        last_s      = (state_r == S_SHIFT) && (cnt_r == CNT_LAST);
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_SHIFT;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_SHIFT;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt_s = S_SHIFT;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register with registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == S_SHIFT);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Operand shifters, carry flop and bit counter; the A register also collects
    // the result bits in its vacated MSB end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r  <= {WIDTH{1'b0}};
            b_sr_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (load_s) begin
            a_sr_r  <= op_a;
            b_sr_r  <= sub ? ~op_b : op_b;
            carry_r <= carry_init(sub, cin);
            cnt_r   <= {CNT_W{1'b0}};
        end else if (state_r == S_SHIFT) begin
            a_sr_r  <= {fa_sum_s, a_sr_r[WIDTH-1:1]};
            b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
            carry_r <= fa_carry_s;
            cnt_r   <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1'b1);
        end
    end

    // Result capture happens only on the final shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else if (last_s) begin
            sum_r  <= {fa_sum_s, a_sr_r[WIDTH-1:1]};
            cout_r <= fa_carry_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with a result scoreboard queue.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic       cin = 1'b0;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int         checks = 0;
    int         errors = 0;
    int         done_pulses = 0;
    int         lat;
    int         p0;
    logic [8:0] sb_q[$];

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic s, input logic c);
        logic [7:0] nb;
        nb = ~b;
        if (s) return {1'b0, a} + {1'b0, nb} + 9'd1;
        else   return {1'b0, a} + {1'b0, b} + {8'd0, c};
    endfunction

    // Drives one request; returns #1 after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic c, input bit sync);
        if (sync) @(negedge clk);
        op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
        sb_q.push_back(model(a, b, s, c));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges until done, checking busy throughout; optionally pokes a
    // spurious start with new operands at SHIFT cycle poke_at.
    task automatic wait_done(input string tag, input int poke_at, output int cyc);
        logic [8:0] exp;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            check({tag, " busy"}, {31'd0, busy}, 32'd1);
            if (cyc == poke_at) begin
                op_a = 8'hAA; start = 1'b1;
            end else if (cyc == poke_at + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, " latency"}, cyc, 32'd8);
        if (done === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check({tag, " sum"}, {24'd0, sum}, {24'd0, exp[7:0]});
            check({tag, " cout"}, {31'd0, cout}, {31'd0, exp[8]});
        end
    endtask

    task automatic settle(input string tag, input logic [7:0] exp_sum);
        @(posedge clk);
        #1;
        check({tag, " done low"}, {31'd0, done}, 32'd0);
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
        check({tag, " sum held"}, {24'd0, sum}, {24'd0, exp_sum});
    endtask

    initial begin
        #12;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst sum", {24'd0, sum}, 32'd0);
        check("rst cout", {31'd0, cout}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        issue(8'h35, 8'h4A, 1'b0, 1'b0, 1'b1);
        wait_done("add", -1, lat);
        settle("add", 8'h7F);

        issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_done("wrap", -1, lat);
        settle("wrap", 8'h00);
        issue(8'h7F, 8'h00, 1'b0, 1'b1, 1'b1);
        wait_done("cin", -1, lat);
        settle("cin", 8'h80);

        issue(8'h10, 8'h20, 1'b1, 1'b0, 1'b1);
        wait_done("sub borrow", -1, lat);
        settle("sub borrow", 8'hF0);
        issue(8'h20, 8'h10, 1'b1, 1'b0, 1'b1);
        wait_done("sub", -1, lat);
        settle("sub", 8'h10);

        p0 = done_pulses;
        issue(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_done("busy ign", 3, lat);
        repeat (12) @(posedge clk);
        #1;
        check("busy ign pulses", done_pulses - p0, 32'd1);
        check("busy ign queue", sb_q.size(), 32'd0);
        check("busy ign sum", {24'd0, sum}, 32'h02);

        // Second request is raised in the DONE cycle, so its 8 counted edges
        // plus the accepting edge put the second done 9 cycles after the first.
        issue(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
        wait_done("b2b first", -1, lat);
        issue(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
        wait_done("b2b second", -1, lat);
        settle("b2b", 8'h10);

        issue(8'h55, 8'h11, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort sum", {24'd0, sum}, 32'd0);
        check("abort cout", {31'd0, cout}, 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = done_pulses;
        repeat (12) @(posedge clk);
        #1;
        check("abort no done", done_pulses - p0, 32'd0);
        check("abort idle", {31'd0, busy}, 32'd0);
        issue(8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
        wait_done("post rst", -1, lat);
        settle("post rst", 8'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
